// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

   // Loader sequencing states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      FILL    = 3'd2,
      HOLDCNT = 3'd3,
      RUN     = 3'd4
   } ldr_state_t;

   // RV32I canonical NOP: addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: streams a program into imem from
// address 0, pads the tail with NOPs, then releases the core from reset.
module imem_loader
   import loader_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH),
   parameter int HOLD  = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_data,
   input  logic          in_last,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          core_reset,
   output logic          done,
   output logic          err_overflow,
   output logic [AW:0]   word_count
);

   localparam int          HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

   ldr_state_t    state_r, next_state_s;
   logic          in_ready_r, imem_we_r, core_reset_r, done_r, err_overflow_r;
   logic [AW-1:0] imem_addr_r, addr_cnt_r;
   logic [31:0]   imem_wdata_r;
   logic [AW:0]   word_count_r;
   logic [HW-1:0] hold_cnt_r;

   logic          in_ready_s, imem_we_s, core_reset_s, done_s, err_overflow_s;
   logic [AW-1:0] imem_addr_s, addr_cnt_s;
   logic [31:0]   imem_wdata_s;
   logic [AW:0]   word_count_s;
   logic [HW-1:0] hold_cnt_s;

   logic          hs_s, at_depth_s;
   logic [AW:0]   wc_inc_s;

   // A word is accepted only while LOAD has its ready asserted
   assign hs_s       = (state_r == LOAD) && in_ready_r && in_valid;
   assign wc_inc_s   = word_count_r + (AW+1)'(1);
   assign at_depth_s = (wc_inc_s == DEPTH_CNT);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decision; leaving LOAD/FILL at DEPTH keeps addresses from wrapping
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) next_state_s = LOAD;
            else       next_state_s = IDLE;
         end
         LOAD: begin
            if (hs_s && (in_last || at_depth_s)) begin
               if (at_depth_s) next_state_s = HOLDCNT;
               else            next_state_s = FILL;
            end else begin
               next_state_s = LOAD;
            end
         end
         FILL: begin
            if (addr_cnt_r == LAST_ADDR) next_state_s = HOLDCNT;
            else                         next_state_s = FILL;
         end
         HOLDCNT: begin
            if (hold_cnt_r == HOLD_LAST) next_state_s = RUN;
            else                         next_state_s = HOLDCNT;
         end
         RUN: begin
            if (start) next_state_s = LOAD;
            else       next_state_s = RUN;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Output/datapath next values; all of these are registered below
   always_comb begin
      in_ready_s     = 1'b0;
      imem_we_s      = 1'b0;
      imem_addr_s    = imem_addr_r;
      imem_wdata_s   = imem_wdata_r;
      word_count_s   = word_count_r;
      err_overflow_s = err_overflow_r;
      addr_cnt_s     = addr_cnt_r;
      hold_cnt_s     = {HW{1'b0}};
      case (state_r)
         IDLE, RUN: begin
            if (start) begin
               word_count_s   = {(AW+1){1'b0}};
               err_overflow_s = 1'b0;
               addr_cnt_s     = {AW{1'b0}};
            end else begin
               word_count_s   = word_count_r;
            end
         end
         LOAD: begin
            // Ready is derived from the next state so no word slips in after the last one
            in_ready_s = (next_state_s == LOAD);
            if (hs_s) begin
               imem_we_s      = 1'b1;
               imem_addr_s    = word_count_r[AW-1:0];
               imem_wdata_s   = in_data;
               word_count_s   = wc_inc_s;
               addr_cnt_s     = addr_cnt_r + AW'(1);
               err_overflow_s = at_depth_s && !in_last;
            end else begin
               imem_we_s      = 1'b0;
            end
         end
         FILL: begin
            imem_we_s    = 1'b1;
            imem_addr_s  = addr_cnt_r;
            imem_wdata_s = NOP_INSTR;
            addr_cnt_s   = addr_cnt_r + AW'(1);
         end
         HOLDCNT: begin
            hold_cnt_s = hold_cnt_r + HW'(1);
         end
         default: begin
            in_ready_s = 1'b0;
         end
      endcase
      // Release on entry to RUN; on restart the reset returns one edge after start
      core_reset_s = !((next_state_s == RUN) || (state_r == RUN));
      done_s       = !core_reset_s;
   end

   // Output and counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_ready_r     <= 1'b0;
         imem_we_r      <= 1'b0;
         imem_addr_r    <= {AW{1'b0}};
         imem_wdata_r   <= 32'h0000_0000;
         core_reset_r   <= 1'b1;
         done_r         <= 1'b0;
         err_overflow_r <= 1'b0;
         word_count_r   <= {(AW+1){1'b0}};
         addr_cnt_r     <= {AW{1'b0}};
         hold_cnt_r     <= {HW{1'b0}};
      end else begin
         in_ready_r     <= in_ready_s;
         imem_we_r      <= imem_we_s;
         imem_addr_r    <= imem_addr_s;
         imem_wdata_r   <= imem_wdata_s;
         core_reset_r   <= core_reset_s;
         done_r         <= done_s;
         err_overflow_r <= err_overflow_s;
         word_count_r   <= word_count_s;
         addr_cnt_r     <= addr_cnt_s;
         hold_cnt_r     <= hold_cnt_s;
      end
   end

   assign in_ready     = in_ready_r;
   assign imem_we      = imem_we_r;
   assign imem_addr    = imem_addr_r;
   assign imem_wdata   = imem_wdata_r;
   assign core_reset   = core_reset_r;
   assign done         = done_r;
   assign err_overflow = err_overflow_r;
   assign word_count   = word_count_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with DEPTH=8, HOLD=4.
module tb_imem_loader;
   import loader_pkg::*;

   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int HOLD  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic [31:0]   in_data = 32'h0;
   logic          in_ready, imem_we, core_reset, done, err_overflow;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   word_count;

   imem_loader #(.DEPTH(DEPTH), .AW(AW), .HOLD(HOLD)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_reset(core_reset), .done(done), .err_overflow(err_overflow),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   logic [AW-1:0] wr_addr [0:255];
   logic [31:0]   wr_data [0:255];
   int            wr_cyc  [0:255];
   int            wr_n = 0;
   int            fall_cyc = 0;
   logic          cr_prev = 1'b1;

   logic [31:0]   prog_w  [0:9];
   logic [31:0]   exp_mem [0:7];
   int            base;

   // Cycle counter used for latency measurements
   always @(posedge clk) cyc <= cyc + 1;

   // Write log and core_reset falling-edge timestamp, sampled mid-cycle
   always @(negedge clk) begin
      if (imem_we && wr_n < 256) begin
         wr_addr[wr_n] = imem_addr;
         wr_data[wr_n] = imem_wdata;
         wr_cyc[wr_n]  = cyc;
         wr_n          = wr_n + 1;
      end
      if (cr_prev && !core_reset) fall_cyc = cyc;
      cr_prev = core_reset;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic set_prog(input int n);
      for (int i = 0; i < 8; i++) exp_mem[i] = (i < n) ? prog_w[i] : NOP_INSTR;
   endtask

   task automatic check_image(input string name);
      check({name, "_nwr"}, 32'(wr_n - base), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (base + i < wr_n) begin
            check($sformatf("%s_addr%0d", name, i), 32'(wr_addr[base+i]), 32'(i));
            check($sformatf("%s_data%0d", name, i), wr_data[base+i], exp_mem[i]);
         end else begin
            check($sformatf("%s_missing%0d", name, i), 32'(wr_n), 32'(base + i + 1));
         end
      end
   endtask

   // Called just after a rising edge; returns just after the handshake edge
   task automatic send_word(input logic [31:0] d, input logic l);
      bit ok = 1'b0;
      int guard = 0;
      in_valid = 1'b1; in_data = d; in_last = l;
      while (!ok && guard < 50) begin
         @(negedge clk); ok = in_ready;
         @(posedge clk); #1; guard++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      if (!ok) check("hs_timeout", 32'(ok), 32'd1);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("start_core_reset", 32'(core_reset), 32'd1);
      check("start_done", 32'(done), 32'd0);
      check("start_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_done();
      int k = 0;
      while (!done && k < 100) begin @(negedge clk); k++; end
      check("done_seen", 32'(done), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      prog_w[0] = 32'h0050_0093; prog_w[1] = 32'h00A0_0113; prog_w[2] = 32'h0020_81B3;
      prog_w[3] = 32'h0030_8213; prog_w[4] = 32'h0040_8293; prog_w[5] = 32'h0050_8313;
      prog_w[6] = 32'h0060_8393; prog_w[7] = 32'h0070_8413; prog_w[8] = 32'h0080_8493;
      prog_w[9] = 32'h0090_8513;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_core_reset", 32'(core_reset), 32'd1);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err_overflow), 32'd0);
      check("rst_wc", 32'(word_count), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // 3-word program, back-to-back, NOP fill, release after HOLD
      base = wr_n;
      do_start();
      for (int i = 0; i < 3; i++) send_word(prog_w[i], (i == 2));
      wait_done();
      set_prog(3);
      check_image("t1");
      check("t1_wc", 32'(word_count), 32'd3);
      check("t1_err", 32'(err_overflow), 32'd0);
      check("t1_core_reset", 32'(core_reset), 32'd0);
      check("t1_hold", 32'(fall_cyc - wr_cyc[base+7]), 32'(HOLD));
      check("t1_nobubble", 32'(wr_cyc[base+7] - wr_cyc[base]), 32'd7);

      // Stalling source: restart from RUN, one idle cycle between words
      base = wr_n;
      do_start();
      for (int i = 0; i < 3; i++) begin
         send_word(prog_w[i], (i == 2));
         @(posedge clk); #1;
      end
      wait_done();
      set_prog(3);
      check_image("t2");
      check("t2_gap", 32'(wr_cyc[base+1] - wr_cyc[base]), 32'd2);
      check("t2_wc", 32'(word_count), 32'd3);

      // Overflow: 8 words accepted without last, further words refused
      base = wr_n;
      do_start();
      for (int i = 0; i < 8; i++) send_word(prog_w[i], 1'b0);
      in_valid = 1'b1; in_data = prog_w[8];
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("t3_ready%0d", k), 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_done();
      set_prog(8);
      check_image("t3");
      check("t3_err", 32'(err_overflow), 32'd1);
      check("t3_wc", 32'(word_count), 32'd8);
      check("t3_hold", 32'(fall_cyc - wr_cyc[base+7]), 32'(HOLD));

      // Exact fit: last on word 8, no fill, no overflow
      base = wr_n;
      do_start();
      for (int i = 0; i < 8; i++) send_word(prog_w[9-i], (i == 7));
      wait_done();
      for (int i = 0; i < 8; i++) exp_mem[i] = prog_w[9-i];
      check_image("t4");
      check("t4_err", 32'(err_overflow), 32'd0);
      check("t4_wc", 32'(word_count), 32'd8);

      // One-word program with start pulsed during FILL
      base = wr_n;
      do_start();
      send_word(prog_w[5], 1'b1);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done();
      for (int i = 0; i < 8; i++) exp_mem[i] = (i == 0) ? prog_w[5] : NOP_INSTR;
      check_image("t5");
      check("t5_wc", 32'(word_count), 32'd1);
      check("t5_core_reset", 32'(core_reset), 32'd0);

      // Asynchronous reset in the middle of LOAD, then reload from 0
      do_start();
      send_word(prog_w[3], 1'b0);
      send_word(prog_w[4], 1'b0);
      #2 reset = 1'b0;
      #1;
      check("t6_core_reset", 32'(core_reset), 32'd1);
      check("t6_in_ready", 32'(in_ready), 32'd0);
      check("t6_we", 32'(imem_we), 32'd0);
      check("t6_done", 32'(done), 32'd0);
      check("t6_wc", 32'(word_count), 32'd0);
      check("t6_addr", 32'(imem_addr), 32'd0);
      check("t6_wdata", imem_wdata, 32'd0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      base = wr_n;
      do_start();
      send_word(prog_w[0], 1'b0);
      send_word(prog_w[1], 1'b1);
      wait_done();
      set_prog(2);
      check_image("t6");
      check("t6_wc2", 32'(word_count), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
